reg_file_mp: RTL and testbench

- Parametrised multi-port integer register file; next generation of the core's 64-bit register file.
- Generalised in width, depth and read-port count. Adds:
  - a second write port (ALU and load writeback retire in the same cycle);
  - x0 hardwired to zero;
  - write-to-read bypass;
  - a per-register pending scoreboard;
  - a sequenced initialisation FSM in place of a reset-edge bulk load.
- Sits between decode (reads, scoreboard set) and writeback (two write ports).

---
 rtl/reg_file_mp.sv | 123 ++++++++++++
 tb/tb_reg_file_mp.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-port integer register file: two write ports, x0 hardwired to zero,
// optional write-to-read bypass, pending scoreboard, sequenced initialisation.
module reg_file_mp #(
    parameter int XLEN      = 64,
    parameter int NREG      = 32,
    parameter int NRD       = 2,
    parameter int INIT_MODE = 1,
    parameter int BYPASS    = 1,
    localparam int AW       = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic                wr0_en,
    input  logic [AW-1:0]       wr0_addr,
    input  logic [XLEN-1:0]     wr0_data,
    input  logic                wr1_en,
    input  logic [AW-1:0]       wr1_addr,
    input  logic [XLEN-1:0]     wr1_data,
    input  logic                busy_set_en,
    input  logic [AW-1:0]       busy_set_addr,
    input  logic                init_req,
    output logic                ready,
    output logic [NREG-1:0]     pending
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     idx;
    logic              run;
    logic              last_idx;
    logic [XLEN-1:0]   init_word;
    logic              wr0_ok, wr1_ok, busy_ok;
    logic [XLEN-1:0]   mem [NREG];
    logic [NREG-1:0]   pending_q, pending_nxt;

    // x0 and out-of-range addresses are never written, set or forwarded.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != '0) && (int'(a) < NREG);
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_INIT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: if (last_idx) state_nxt = ST_RUN;
            ST_RUN:  if (init_req) state_nxt = ST_INIT;
            default: state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        run   = (state == ST_RUN);
        ready = run;
    end

    assign last_idx  = (idx == AW'(NREG - 1));
    assign init_word = (INIT_MODE != 0) ? XLEN'(idx) : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                idx <= '0;
        else if (state == ST_INIT) idx <= last_idx ? '0 : idx + AW'(1);
        else if (init_req)         idx <= '0;
    end

    assign wr0_ok  = run && wr0_en && addr_ok(wr0_addr);
    assign wr1_ok  = run && wr1_en && addr_ok(wr1_addr);
    assign busy_ok = run && busy_set_en && addr_ok(busy_set_addr);

    // Storage is not reset; INIT sweeps every entry instead. wr1 is written last so it wins.
    always_ff @(posedge clock) begin
        if (!run) begin
            mem[idx] <= init_word;
        end else begin
            if (wr0_ok) mem[wr0_addr] <= wr0_data;
            if (wr1_ok) mem[wr1_addr] <= wr1_data;
        end
    end

    // A fresh issue outranks a retiring writeback to the same register.
    always_comb begin
        pending_nxt = pending_q;
        if (wr0_ok)  pending_nxt[wr0_addr]      = 1'b0;
        if (wr1_ok)  pending_nxt[wr1_addr]      = 1'b0;
        if (busy_ok) pending_nxt[busy_set_addr] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)   pending_q <= '0;
        else if (run) pending_q <= init_req ? '0 : pending_nxt;
    end

    assign pending = pending_q;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] word;

        assign ra = rd_addr[k*AW +: AW];

        always_comb begin
            word = '0;
            if (run && addr_ok(ra)) begin
                if ((BYPASS != 0) && wr1_ok && (wr1_addr == ra))
                    word = wr1_data;
                else if ((BYPASS != 0) && wr0_ok && (wr0_addr == ra))
                    word = wr0_data;
                else
                    word = mem[ra];
            end
        end

        assign rd_data[k*XLEN +: XLEN] = word;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: default, no-bypass and small (24 regs, 4 ports, zero-init) builds.
module tb_reg_file_mp;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         reset;
    logic [9:0]   rd_addr;
    logic [127:0] rd_data_a, rd_data_b;
    logic         wr0_en, wr1_en, busy_set_en, init_req;
    logic [4:0]   wr0_addr, wr1_addr, busy_set_addr;
    logic [63:0]  wr0_data, wr1_data;
    logic         ready_a, ready_b;
    logic [31:0]  pending_a, pending_b;

    logic [19:0]  c_rd_addr;
    logic [255:0] c_rd_data;
    logic         c_wr0_en, c_wr1_en, c_busy_set_en, c_init_req, c_ready;
    logic [4:0]   c_wr0_addr, c_wr1_addr, c_busy_set_addr;
    logic [63:0]  c_wr0_data, c_wr1_data;
    logic [23:0]  c_pending;

    reg_file_mp dut_a (
        .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_a),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr),
        .init_req(init_req), .ready(ready_a), .pending(pending_a)
    );

    reg_file_mp #(.BYPASS(0)) dut_b (
        .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr),
        .init_req(init_req), .ready(ready_b), .pending(pending_b)
    );

    reg_file_mp #(.NREG(24), .NRD(4), .INIT_MODE(0)) dut_c (
        .clock(clock), .reset(reset), .rd_addr(c_rd_addr), .rd_data(c_rd_data),
        .wr0_en(c_wr0_en), .wr0_addr(c_wr0_addr), .wr0_data(c_wr0_data),
        .wr1_en(c_wr1_en), .wr1_addr(c_wr1_addr), .wr1_data(c_wr1_data),
        .busy_set_en(c_busy_set_en), .busy_set_addr(c_busy_set_addr),
        .init_req(c_init_req), .ready(c_ready), .pending(c_pending)
    );

    int checks = 0;
    int errors = 0;

    // Reference state for the 32-entry builds (both share inputs and storage behaviour).
    logic [63:0] m_mem [32];
    logic [31:0] m_pend;

    task automatic idle_inputs();
        wr0_en = 0; wr1_en = 0; busy_set_en = 0; init_req = 0;
        wr0_addr = 0; wr1_addr = 0; busy_set_addr = 0;
        wr0_data = 0; wr1_data = 0; rd_addr = 0;
        c_wr0_en = 0; c_wr1_en = 0; c_busy_set_en = 0; c_init_req = 0;
        c_wr0_addr = 0; c_wr1_addr = 0; c_busy_set_addr = 0;
        c_wr0_data = 0; c_wr1_data = 0; c_rd_addr = 0;
    endtask

    task automatic model_init();
        for (int i = 0; i < 32; i++) m_mem[i] = 64'(i);
        m_pend = '0;
    endtask

    function automatic logic [63:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 0) return 64'h0;
        if (byp && wr1_en && wr1_addr == a) return wr1_data;
        if (byp && wr0_en && wr0_addr == a) return wr0_data;
        return m_mem[a];
    endfunction

    task automatic model_edge();
        if (wr0_en && wr0_addr != 0) m_mem[wr0_addr] = wr0_data;
        if (wr1_en && wr1_addr != 0) m_mem[wr1_addr] = wr1_data;
        if (wr0_en) m_pend[wr0_addr] = 1'b0;
        if (wr1_en) m_pend[wr1_addr] = 1'b0;
        if (busy_set_en) m_pend[busy_set_addr] = 1'b1;
        m_pend[0] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    function automatic logic [4:0] pick();
        if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    task automatic test_reset();
        int na, nb, nc;
        reset = 1'b0;
        idle_inputs();
        rd_addr = {5'd31, 5'd5};
        #12;
        checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready_a); end
        checks++; if (pending_a !== 32'h0) begin errors++; $display("FAIL reset_pending got %h exp 0", pending_a); end
        checks++; if (rd_data_a !== 128'h0) begin errors++; $display("FAIL reset_rd got %h exp 0", rd_data_a); end
        checks++; if (c_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_c got %b exp 0", c_ready); end
        @(negedge clock);
        reset = 1'b1;
        na = 0; nb = 0; nc = 0;
        for (int n = 1; n <= 80; n++) begin
            @(posedge clock); #1;
            if (ready_a && na == 0) na = n;
            if (ready_b && nb == 0) nb = n;
            if (c_ready && nc == 0) nc = n;
            if (na != 0 && nb != 0 && nc != 0) break;
        end
        checks++; if (na != 32) begin errors++; $display("FAIL init_edges_a got %0d exp 32", na); end
        checks++; if (nb != 32) begin errors++; $display("FAIL init_edges_b got %0d exp 32", nb); end
        checks++; if (nc != 24) begin errors++; $display("FAIL init_edges_c got %0d exp 24", nc); end
        model_init();
    endtask

    task automatic test_init_values();
        rd_addr = {5'd31, 5'd5};
        #4;
        checks++; if (rd_data_a[63:0] !== 64'h5) begin errors++; $display("FAIL init_x5 got %h exp 5", rd_data_a[63:0]); end
        checks++; if (rd_data_a[127:64] !== 64'h1F) begin errors++; $display("FAIL init_x31 got %h exp 1f", rd_data_a[127:64]); end
        checks++; if (rd_data_b[127:64] !== 64'h1F) begin errors++; $display("FAIL init_x31_b got %h exp 1f", rd_data_b[127:64]); end
        tick();
    endtask

    task automatic test_bypass();
        wr0_en = 1; wr0_addr = 5'd3; wr0_data = 64'hDEAD_BEEF;
        rd_addr = {5'd3, 5'd3};
        #4;
        checks++; if (rd_data_a[63:0] !== 64'hDEAD_BEEF) begin errors++; $display("FAIL bypass_same got %h exp deadbeef", rd_data_a[63:0]); end
        checks++; if (rd_data_b[63:0] !== 64'h3) begin errors++; $display("FAIL nobypass_same got %h exp 3", rd_data_b[63:0]); end
        tick();
        wr0_en = 0;
        #4;
        checks++; if (rd_data_a[63:0] !== 64'hDEAD_BEEF) begin errors++; $display("FAIL bypass_after got %h exp deadbeef", rd_data_a[63:0]); end
        checks++; if (rd_data_b[127:64] !== 64'hDEAD_BEEF) begin errors++; $display("FAIL nobypass_after got %h exp deadbeef", rd_data_b[127:64]); end
        tick();
    endtask

    task automatic test_same_addr();
        wr0_en = 1; wr0_addr = 5'd7; wr0_data = 64'h1111;
        wr1_en = 1; wr1_addr = 5'd7; wr1_data = 64'h2222;
        rd_addr = {5'd7, 5'd7};
        #4;
        checks++; if (rd_data_a[63:0] !== 64'h2222) begin errors++; $display("FAIL dual_bypass got %h exp 2222", rd_data_a[63:0]); end
        tick();
        wr0_en = 0; wr1_en = 0;
        #4;
        checks++; if (rd_data_a[63:0] !== 64'h2222) begin errors++; $display("FAIL dual_store_a got %h exp 2222", rd_data_a[63:0]); end
        checks++; if (rd_data_b[63:0] !== 64'h2222) begin errors++; $display("FAIL dual_store_b got %h exp 2222", rd_data_b[63:0]); end
        wr1_en = 1; wr1_addr = 5'd0; wr1_data = 64'hFFFF;
        rd_addr = {5'd0, 5'd0};
        #1;
        checks++; if (rd_data_a[63:0] !== 64'h0) begin errors++; $display("FAIL x0_bypass got %h exp 0", rd_data_a[63:0]); end
        tick();
        wr1_en = 0;
        #4;
        checks++; if (rd_data_a[63:0] !== 64'h0) begin errors++; $display("FAIL x0_after got %h exp 0", rd_data_a[63:0]); end
        checks++; if (rd_data_b[63:0] !== 64'h0) begin errors++; $display("FAIL x0_after_b got %h exp 0", rd_data_b[63:0]); end
        tick();
    endtask

    task automatic test_scoreboard();
        busy_set_en = 1; busy_set_addr = 5'd9;
        tick();
        checks++; if (pending_a[9] !== 1'b1) begin errors++; $display("FAIL sb_set got %b exp 1", pending_a[9]); end
        busy_set_en = 0; wr0_en = 1; wr0_addr = 5'd9; wr0_data = 64'h99;
        tick();
        checks++; if (pending_a[9] !== 1'b0) begin errors++; $display("FAIL sb_clear got %b exp 0", pending_a[9]); end
        wr0_en = 0; busy_set_en = 1; busy_set_addr = 5'd9;
        wr1_en = 1; wr1_addr = 5'd9; wr1_data = 64'h9A;
        tick();
        checks++; if (pending_a[9] !== 1'b1) begin errors++; $display("FAIL sb_set_wins got %b exp 1", pending_a[9]); end
        wr1_en = 0; busy_set_addr = 5'd0;
        tick();
        busy_set_en = 0;
        checks++; if (pending_a[0] !== 1'b0) begin errors++; $display("FAIL sb_x0 got %b exp 0", pending_a[0]); end
        checks++; if (pending_b !== m_pend) begin errors++; $display("FAIL sb_vec got %h exp %h", pending_b, m_pend); end
    endtask

    task automatic test_random(input int n);
        logic [63:0] e;
        for (int it = 0; it < n; it++) begin
            wr0_en = 1'($urandom_range(0, 1)); wr0_addr = pick(); wr0_data = {$urandom, $urandom};
            wr1_en = 1'($urandom_range(0, 1)); wr1_addr = pick(); wr1_data = {$urandom, $urandom};
            busy_set_en = ($urandom_range(0, 3) == 0); busy_set_addr = pick();
            rd_addr = {pick(), pick()};
            #4;
            for (int k = 0; k < 2; k++) begin
                e = exp_rd(rd_addr[k*5 +: 5], 1'b1);
                checks++;
                if (rd_data_a[k*64 +: 64] !== e) begin
                    errors++; $display("FAIL rand_rd_a port %0d got %h exp %h", k, rd_data_a[k*64 +: 64], e);
                end
                e = exp_rd(rd_addr[k*5 +: 5], 1'b0);
                checks++;
                if (rd_data_b[k*64 +: 64] !== e) begin
                    errors++; $display("FAIL rand_rd_b port %0d got %h exp %h", k, rd_data_b[k*64 +: 64], e);
                end
            end
            tick();
            checks++; if (pending_a !== m_pend) begin errors++; $display("FAIL rand_pend got %h exp %h", pending_a, m_pend); end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        int na;
        reset = 1'b0;
        #1;
        checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL mid_async_ready got %b exp 0", ready_a); end
        checks++; if (pending_a !== 32'h0) begin errors++; $display("FAIL mid_async_pend got %h exp 0", pending_a); end
        @(negedge clock);
        reset = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b0;
        wr0_en = 1; wr0_addr = 5'd12; wr0_data = 64'hBAD;
        wr1_en = 1; wr1_addr = 5'd12; wr1_data = 64'hBAD1;
        busy_set_en = 1; busy_set_addr = 5'd12; init_req = 1;
        rd_addr = {5'd12, 5'd5};
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        na = 0;
        for (int n = 1; n <= 80; n++) begin
            @(posedge clock); #1;
            if (n == 5) begin
                checks++; if (rd_data_a !== 128'h0) begin errors++; $display("FAIL init_rd_zero got %h exp 0", rd_data_a); end
            end
            if (n == 20) idle_inputs();
            if (ready_a) begin na = n; break; end
        end
        checks++; if (na != 32) begin errors++; $display("FAIL mid_init_edges got %0d exp 32", na); end
        model_init();
        rd_addr = {5'd0, 5'd12};
        #4;
        checks++; if (rd_data_a[63:0] !== 64'hC) begin errors++; $display("FAIL mid_x12 got %h exp c", rd_data_a[63:0]); end
        checks++; if (pending_a !== 32'h0) begin errors++; $display("FAIL mid_pend got %h exp 0", pending_a); end
        tick();
    endtask

    task automatic test_small();
        int nc;
        checks++; if (c_ready !== 1'b1) begin errors++; $display("FAIL small_ready got %b exp 1", c_ready); end
        c_rd_addr = {5'd17, 5'd23, 5'd5, 5'd0};
        #4;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (c_rd_data[k*64 +: 64] !== 64'h0) begin
                errors++; $display("FAIL small_zero port %0d got %h exp 0", k, c_rd_data[k*64 +: 64]);
            end
        end
        @(posedge clock); #1;
        c_wr0_en = 1; c_wr0_addr = 5'd30; c_wr0_data = 64'h3030;
        c_wr1_en = 1; c_wr1_addr = 5'd5;  c_wr1_data = 64'h55;
        c_busy_set_en = 1; c_busy_set_addr = 5'd7;
        c_rd_addr = {5'd0, 5'd0, 5'd5, 5'd30};
        #4;
        checks++; if (c_rd_data[63:0] !== 64'h0) begin errors++; $display("FAIL small_oob_bypass got %h exp 0", c_rd_data[63:0]); end
        checks++; if (c_rd_data[127:64] !== 64'h55) begin errors++; $display("FAIL small_bypass got %h exp 55", c_rd_data[127:64]); end
        @(posedge clock); #1;
        c_wr0_en = 0; c_wr1_en = 0; c_busy_set_en = 0;
        #4;
        checks++; if (c_rd_data[63:0] !== 64'h0) begin errors++; $display("FAIL small_oob got %h exp 0", c_rd_data[63:0]); end
        checks++; if (c_rd_data[127:64] !== 64'h55) begin errors++; $display("FAIL small_x5 got %h exp 55", c_rd_data[127:64]); end
        checks++; if (c_pending !== 24'h80) begin errors++; $display("FAIL small_pend got %h exp 80", c_pending); end
        @(posedge clock); #1;
        c_init_req = 1;
        @(posedge clock); #1;
        c_init_req = 0;
        checks++; if (c_ready !== 1'b0) begin errors++; $display("FAIL soft_init_ready got %b exp 0", c_ready); end
        checks++; if (c_pending !== 24'h0) begin errors++; $display("FAIL soft_init_pend got %h exp 0", c_pending); end
        nc = 0;
        for (int n = 1; n <= 80; n++) begin
            @(posedge clock); #1;
            if (c_ready) begin nc = n; break; end
        end
        checks++; if (nc != 24) begin errors++; $display("FAIL soft_init_edges got %0d exp 24", nc); end
        #3;
        checks++; if (c_rd_data[127:64] !== 64'h0) begin errors++; $display("FAIL soft_init_x5 got %h exp 0", c_rd_data[127:64]); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_init_values();
        test_bypass();
        test_same_addr();
        test_scoreboard();
        test_random(200);
        test_reset_mid();
        test_small();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
